mac_mdc_kernel: RTL
===================

Name: mac_mdc_kernel

Overview:
- Compute kernel behind the MAC HWPE kernel adapter. It is the responder side of the adapter's start/done/idle/ready block-level handshake.
- It consumes streams a, b and c and produces stream d, all with valid/ready handshakes.
- Two modes, selected by reg_simple_mul: element-wise multiply-shift-add, or multiply-accumulate-reduce.
- Custom registers are sampled at start and held for the whole job.

Parameters:
DATA_WIDTH, 32, width of a/b/c/d data (signed two's complement)
LEN_WIDTH, 16, width of reg_len
SHIFT_WIDTH, 8, width of reg_shift

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
ap_start  in  1  job request from kernel adapter
ap_done  out  1  one-cycle pulse, job complete
ap_idle  out  1  high while kernel idle
ap_ready  out  1  one-cycle pulse, last input beat accepted
reg_simple_mul  in  1  1 = element-wise mode, 0 = MAC mode
reg_shift  in  SHIFT_WIDTH  arithmetic right-shift of each product
reg_len  in  LEN_WIDTH  number of a/b beats per job
a_TDATA, b_TDATA, c_TDATA  in  DATA_WIDTH  input stream data
a_TVALID, b_TVALID, c_TVALID  in  1  input valid
a_TREADY, b_TREADY, c_TREADY  out  1  input ready
d_TDATA  out  DATA_WIDTH  output data (registered)
d_TVALID  out  1  output valid
d_TREADY  in  1  output ready

Behaviour:
- Reset (ap_rst sampled high on an ap_clk edge; overrides everything, including mid-job):
  - state IDLE; ap_idle=1.
  - ap_done, ap_ready, all TREADY, d_TVALID = 0; d_TDATA = 0.
  - beat counter = 0, acc = 0, output register empty.
  - Partial job discarded.
- State IDLE:
  - ap_idle=1, all TREADY=0.
  - On ap_start=1: latch reg_simple_mul, reg_shift (capped at 63), reg_len; clear cnt and acc.
  - If latched len==0: go to DONE, pulse ap_ready in that cycle, emit no output.
  - Otherwise go to RUN.
  - ap_idle drops the cycle after ap_start is accepted.
- State RUN, per-beat arithmetic:
  - p = (a*b), full 2*DATA_WIDTH signed product, then arithmetic >>> shift.
  - pt = lower DATA_WIDTH bits of p.
  - All adds wrap modulo 2^DATA_WIDTH.
- RUN, element-wise mode (simple_mul=1):
  - A beat fires when a, b and c are all valid and the output register is empty or draining that cycle.
  - TREADY is asserted on all three only under that condition (join; no TREADY depends on its own TVALID).
  - On fire: d register <= pt + c; d_TVALID=1; cnt++.
  - One beat per cycle sustained while d_TREADY=1.
- RUN, MAC mode (simple_mul=0):
  - Beat 0 joins a, b and c; c is the accumulator seed. acc <= c + pt.
  - Beats 1..len-1 join a and b only; c_TREADY=0. acc <= acc + pt.
  - No output until the last beat.
  - On the last beat the final sum (acc + pt, or c + pt when len==1) is loaded directly into the d register.
- RUN exit: on the cycle the beat with cnt==len-1 fires, pulse ap_ready and go to DRAIN.
- State DRAIN:
  - No TREADY asserted.
  - d_TVALID held with stable d_TDATA until d_TREADY.
  - On the d handshake, go to DONE.
  - If the output register is already empty on entry, go to DONE directly.
- State DONE: ap_done=1 for exactly one cycle, then IDLE. ap_start is ignored in RUN, DRAIN and DONE.
- Output register rules: a d handshake occurs when d_TVALID & d_TREADY; simultaneous drain and load is allowed in the same cycle.
- Latency:
  - First TREADY at the earliest one cycle after ap_start.
  - d_TVALID one cycle after the beat fires.
  - ap_done one cycle after the final d handshake.
- Register changes during a job have no effect.

Test Plan:
- Element-wise job: simple_mul=1, shift=0, len=4, a={1,2,3,4}, b={5,6,7,8}, c={10,10,10,10}, d_TREADY=1 → d={15,22,31,42}; one ap_ready and one ap_done pulse; ap_idle low from the cycle after start to the cycle after done.
- MAC job: simple_mul=0, shift=1, len=3, a={4,-6,8}, b={3,3,3}, c seed=100 → single d = 100+6-9+12 = 109; c accepted exactly once.
- Backpressure: element-wise, len=3, d_TREADY low for 5 cycles after the first d_TVALID → d_TDATA stable, no input TREADY, no data loss; outputs in order after release.
- len=0 with ap_start → ap_ready and ap_done pulses, no d_TVALID, return to IDLE within 2 cycles.
- Overflow and shift extremes: a=b=0x7FFFFFFF, shift=0 → d lower 32 bits = 0x00000001; a=-1, b=1, shift=200 → capped at 63, pt = -1 (0xFFFFFFFF).
- Reset mid-job, plus a new start: ap_rst asserted in RUN after 2 of 4 beats → next cycle all outputs at reset values; a new ap_start then runs a full correct job. ap_start held high through DONE triggers the next job only from IDLE.

Source files
------------

// File: rtl/mac_mdc_kernel.sv
// Purpose : MAC compute kernel behind the HWPE kernel adapter (ap_start/done/idle/ready responder).
// Latency : first TREADY one cycle after ap_start, d_TVALID one cycle after a beat fires,
//           ap_done one cycle after the final d handshake.
// Backpressure: inputs are accepted only when the d register is empty or draining that cycle.
//
// Ports:
//   ap_clk, ap_rst                  clock, synchronous active-high reset
//   ap_start/ap_done/ap_idle/ap_ready  block-level handshake with the kernel adapter
//   reg_simple_mul, reg_shift, reg_len  job configuration, sampled on ap_start
//   a_*, b_*, c_*                   input streams (valid/ready)
//   d_*                             output stream (registered data)
module mac_mdc_kernel #(
   parameter int DATA_WIDTH  = 32,
   parameter int LEN_WIDTH   = 16,
   parameter int SHIFT_WIDTH = 8
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   input  logic                   ap_start,
   output logic                   ap_done,
   output logic                   ap_idle,
   output logic                   ap_ready,
   input  logic                   reg_simple_mul,
   input  logic [SHIFT_WIDTH-1:0] reg_shift,
   input  logic [LEN_WIDTH-1:0]   reg_len,
   input  logic [DATA_WIDTH-1:0]  a_TDATA,
   input  logic                   a_TVALID,
   output logic                   a_TREADY,
   input  logic [DATA_WIDTH-1:0]  b_TDATA,
   input  logic                   b_TVALID,
   output logic                   b_TREADY,
   input  logic [DATA_WIDTH-1:0]  c_TDATA,
   input  logic                   c_TVALID,
   output logic                   c_TREADY,
   output logic [DATA_WIDTH-1:0]  d_TDATA,
   output logic                   d_TVALID,
   input  logic                   d_TREADY
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

   state_e                  state_q, state_d;
   logic                    mode_q, mode_d;
   logic [5:0]              shift_q, shift_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   acc_q, acc_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;
   logic                    dvld_q, dvld_d;

   logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
   logic [DATA_WIDTH-1:0]   pt, base, sum;
   logic [5:0]              shift_cap;
   logic                    need_c, last_beat, out_free, beat_ok, d_hs;

   // Full-width signed product, shifted, then truncated back to the data width.
   assign a_ext = {{DATA_WIDTH{a_TDATA[DATA_WIDTH-1]}}, a_TDATA};
   assign b_ext = {{DATA_WIDTH{b_TDATA[DATA_WIDTH-1]}}, b_TDATA};
   assign prod  = a_ext * b_ext;
   assign pt    = DATA_WIDTH'(prod >>> shift_q);

   // Shifts of 64 or more are clamped to 63: the result is then pure sign fill.
   assign shift_cap = (32'(reg_shift) > 32'd63) ? 6'd63 : 6'(reg_shift);

   // c joins every beat in element-wise mode, only the seed beat in MAC mode.
   assign need_c    = mode_q || (cnt_q == '0);
   assign last_beat = (cnt_q + LEN_ONE) == len_q;
   assign base      = need_c ? c_TDATA : acc_q;
   assign sum       = base + pt;
   assign d_hs      = dvld_q && d_TREADY;
   assign out_free  = !dvld_q || d_TREADY;
   assign beat_ok   = out_free && a_TVALID && b_TVALID && (c_TVALID || !need_c);

   assign ap_done  = (state_q == S_DONE);
   assign ap_idle  = (state_q == S_IDLE);
   assign d_TVALID = dvld_q;
   assign d_TDATA  = dat_q;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         shift_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         dat_q   <= '0;
         dvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         shift_q <= shift_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dat_q   <= dat_d;
         dvld_q  <= dvld_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      shift_d  = shift_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      dat_d    = dat_q;
      dvld_d   = d_hs ? 1'b0 : dvld_q;
      ap_ready = 1'b0;
      a_TREADY = 1'b0;
      b_TREADY = 1'b0;
      c_TREADY = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               mode_d  = reg_simple_mul;
               shift_d = shift_cap;
               len_d   = reg_len;
               cnt_d   = '0;
               acc_d   = '0;
               if (reg_len == '0) begin
                  ap_ready = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_RUN;
               end
            end
         end
         S_RUN: begin
            // Each ready looks only at the other streams' valids, never its own.
            a_TREADY = out_free && b_TVALID && (c_TVALID || !need_c);
            b_TREADY = out_free && a_TVALID && (c_TVALID || !need_c);
            c_TREADY = out_free && need_c && a_TVALID && b_TVALID;
            if (beat_ok) begin
               cnt_d = cnt_q + LEN_ONE;
               if (mode_q || last_beat) begin
                  dat_d  = sum;
                  dvld_d = 1'b1;
               end else begin
                  acc_d  = sum;
               end
               if (last_beat) begin
                  ap_ready = 1'b1;
                  state_d  = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!dvld_q || d_TREADY) state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
